req_ack_arbiter: RTL and testbench

//  Shares one downstream req/ack target among N_REQ upstream requesters using round-robin arbitration.

---
 rtl/req_ack_pkg.sv | 14 +
 rtl/req_ack_arbiter_rr.sv | 39 +++
 rtl/req_ack_arbiter.sv | 116 +++++++++++
 tb/tb_req_ack_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and defaults for the round-robin req/ack arbiter.
package req_ack_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/req_ack_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant,
    output logic             valid
);

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

    // idx[k] is the requester index examined at priority k (k=0 is ptr itself)
    logic [ID_W-1:0] idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_idx
            logic [ID_W:0] sum;
            assign sum     = {1'b0, ptr} + (ID_W+1)'(gi);
            assign idx[gi] = (sum >= N_EXT) ? ID_W'(sum - N_EXT) : ID_W'(sum);
        end
    endgenerate

    // Scan in priority order and keep the first hit.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!valid && req[idx[i]]) begin
                grant = idx[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_ack_arbiter.sv
// Shares one downstream req/ack target among N_REQ requesters. Each grant
// issues one dn_req pulse, waits for dn_ack (or times out), then returns a
// done/err pulse to the owner. Acks outside the wait window are flagged.
module req_ack_arbiter
    import req_ack_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] up_req,
    output logic [N_REQ-1:0] up_done,
    output logic             up_err,
    output logic             dn_req,
    input  logic             dn_ack,
    output logic             busy,
    output logic [ID_W-1:0]  owner,
    output logic             spurious_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t          state_reg, state_next;
    logic [ID_W-1:0] owner_reg, owner_next;
    logic [ID_W-1:0] ptr_reg,   ptr_next;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;
    logic            err_reg,   err_next;
    logic            spur_reg,  spur_next;

    logic [ID_W-1:0] arb_grant;
    logic            arb_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (up_req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // State and datapath registers; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            spur_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            spur_reg  <= spur_next;
        end
    end

    // Next-state and output decode; outputs depend on state only, so they
    // are all zero while reset holds the machine in IDLE.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        // Any ack seen outside the wait window is a protocol violation.
        spur_next  = spur_reg | (dn_ack && (state_reg != WAIT));
        dn_req     = 1'b0;
        up_done    = '0;
        up_err     = 1'b0;
        busy       = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    owner_next = arb_grant;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                dn_req     = 1'b1;
                cnt_next   = CNT_W'(1);
                state_next = WAIT;
            end
            WAIT: begin
                if (dn_ack) begin
                    err_next   = 1'b0;
                    state_next = DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    // Counter stops here, so it never wraps.
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                up_done[owner_reg] = 1'b1;
                up_err             = err_reg;
                ptr_next   = (owner_reg == ID_W'(N_REQ - 1)) ? '0 : owner_reg + 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign owner        = owner_reg;
    assign spurious_ack = spur_reg;

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timeline-based model.
module tb_req_ack_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  up_req;
    logic [N-1:0]  up_done;
    logic          up_err;
    logic          dn_req;
    logic          dn_ack;
    logic          busy;
    logic [IW-1:0] owner;
    logic          spurious_ack;

    int checks = 0;
    int errors = 0;

    req_ack_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_req       (up_req),
        .up_done      (up_done),
        .up_err       (up_err),
        .dn_req       (dn_req),
        .dn_ack       (dn_ack),
        .busy         (busy),
        .owner        (owner),
        .spurious_ack (spurious_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is a timeline: grant decided in idle cycle n, dn_req at
    // s=n+1, ack window s+1..s+TMO, done one cycle after the ack or window end.
    int  cyc = 0;
    bit  m_busy = 0;
    int  m_start = 0;
    int  m_done = -1;
    int  m_owner = 0;
    int  m_ptr = 0;
    bit  m_err = 0;
    bit  m_spur = 0;

    always @(negedge clk) begin
        int  exp_done;
        bit  in_wait;
        bit  found;
        int  j;
        if (!rst_n) begin
            chk("rst_up_done", up_done, 0);
            chk("rst_up_err", up_err, 0);
            chk("rst_dn_req", dn_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_owner", owner, 0);
            chk("rst_spurious", spurious_ack, 0);
            m_busy = 0; m_ptr = 0; m_owner = 0; m_spur = 0; m_done = -1; m_err = 0;
        end else begin
            exp_done = (m_busy && cyc == m_done) ? (1 << m_owner) : 0;
            chk("m_up_done", up_done, exp_done);
            chk("m_up_err", up_err, (exp_done != 0) ? m_err : 0);
            chk("m_dn_req", dn_req, (m_busy && cyc == m_start) ? 1 : 0);
            chk("m_busy", busy, m_busy);
            chk("m_owner", owner, m_owner);
            chk("m_spurious", spurious_ack, m_spur);
            if (up_done != 0)
                $display("txn: cycle %0d up_done %b up_err %0d", cyc, up_done, up_err);

            // advance using this cycle's inputs
            in_wait = m_busy && (cyc >= m_start + 1) && (m_done < 0);
            if (dn_ack && !in_wait) m_spur = 1;
            if (in_wait) begin
                if (dn_ack) begin
                    m_done = cyc + 1; m_err = 0;
                end else if (cyc == m_start + TMO) begin
                    m_done = cyc + 1; m_err = 1;
                end
            end else if (m_busy && cyc == m_done) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end else if (!m_busy && up_req != 0) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    j = (m_ptr + i) % N;
                    if (!found && up_req[j]) begin
                        found = 1;
                        m_owner = j;
                    end
                end
                m_busy  = 1;
                m_start = cyc + 1;
                m_done  = -1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_n  = 1'b0;
        up_req = '0;
        dn_ack = 1'b0;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_owner", owner, 0);
        chk("reset_spurious", spurious_ack, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single request, nominal ack
        up_req = 4'b0001;
        tick();
        chk("t1_dn_req", dn_req, 1);
        chk("t1_owner", owner, 0);
        tick();
        chk("t1_dn_req_pulse", dn_req, 0);
        tick();
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t1_up_done", up_done, 4'b0001);
        chk("t1_up_err", up_err, 0);
        up_req = '0;
        tick();
        chk("t1_idle", busy, 0);

        // 2: all requesting, grants rotate 0,1,2,3,0
        do_reset();
        up_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_owner", owner, exp_order[k]);
            chk("t2_dn_req", dn_req, 1);
            tick();
            tick();
            dn_ack = 1'b1;
            tick();
            dn_ack = 1'b0;
            chk("t2_up_done", up_done, 1 << exp_order[k]);
            tick();
            chk("t2_idle", busy, 0);
        end
        up_req = '0;

        // 3: timeout on requester 2
        tick();
        up_req = 4'b0100;
        tick();
        chk("t3_owner", owner, 2);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("t3_no_done", up_done, 0);
        end
        tick();
        chk("t3_up_done", up_done, 4'b0100);
        chk("t3_up_err", up_err, 1);
        up_req = '0;
        tick();
        chk("t3_idle", busy, 0);

        // 4: spurious acks in IDLE and ISSUE
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t4_spur_idle", spurious_ack, 1);
        up_req = 4'b1000;
        tick();
        chk("t4_dn_req", dn_req, 1);
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t4_still_busy", busy, 1);
        tick();
        chk("t4_no_done", up_done, 0);
        tick();
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t4_up_done", up_done, 4'b1000);
        chk("t4_up_err", up_err, 0);
        up_req = '0;
        tick();
        chk("t4_spur_sticky", spurious_ack, 1);

        // 5: late ack at wait_cnt 7, second ack in DONE
        do_reset();
        up_req = 4'b0001;
        tick();
        repeat (7) tick();
        dn_ack = 1'b1;
        tick();
        chk("t5_up_done", up_done, 4'b0001);
        chk("t5_up_err", up_err, 0);
        chk("t5_spur_clear", spurious_ack, 0);
        up_req = '0;
        tick();
        dn_ack = 1'b0;
        chk("t5_spur_done", spurious_ack, 1);
        chk("t5_idle", busy, 0);

        // 6: reset mid-WAIT
        up_req = 4'b0010;
        tick();
        chk("t6_owner", owner, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_owner", owner, 0);
        chk("t6_rst_spur", spurious_ack, 0);
        chk("t6_rst_dn_req", dn_req, 0);
        up_req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        up_req = 4'b1000;
        tick();
        chk("t6_owner_after", owner, 3);
        tick();
        tick();
        dn_ack = 1'b1;
        tick();
        dn_ack = 1'b0;
        chk("t6_up_done", up_done, 4'b1000);
        up_req = '0;
        tick();

        // randomized traffic: frequent acks, then sparse acks (timeouts), with resets
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 3) == 0) up_req = 4'($urandom_range(0, 15));
                dn_ack = (seg % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
                tick();
            end
            up_req = '0;
            dn_ack = 1'b0;
            do_reset();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
